// File: rtl/nios_jtag_dbg_pkg.sv
// Shared constants, types and the command decode for the Nios II OCI JTAG debug
// system-clock stage.
package nios_jtag_dbg_pkg;

  localparam int SR_W_DEF = 38;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'b00,
    IR_TRACEMEM  = 2'b01,
    IR_BREAK     = 2'b10,
    IR_TRACECTRL = 2'b11
  } ir_e;

  localparam int JDO_B37 = 37;
  localparam int JDO_B36 = 36;
  localparam int JDO_B35 = 35;
  localparam int JDO_B34 = 34;
  localparam int JDO_B15 = 15;

  typedef struct packed {
    logic ocimem_a;
    logic ocimem_b;
    logic no_ocimem_a;
    logic tracemem_a;
    logic tracemem_b;
    logic no_tracemem_a;
    logic break_a;
    logic break_b;
    logic break_c;
    logic no_break_a;
    logic no_break_b;
    logic no_break_c;
    logic tracectrl;
  } take_t;

  // Each IR selects a disjoint group, so at most one field is ever set.
  function automatic take_t decode_cmd(input ir_e  ir,
                                       input logic j37,
                                       input logic j36,
                                       input logic j35,
                                       input logic j34,
                                       input logic j15);
    take_t t;
    t = '0;
    unique case (ir)
      IR_OCIMEM: begin
        t.ocimem_a    = ~j35 & j34;
        t.no_ocimem_a = ~j35 & ~j34;
        t.ocimem_b    = j35;
      end
      IR_TRACEMEM: begin
        t.tracemem_a    = ~j37 & j36;
        t.no_tracemem_a = ~j37 & ~j36;
        t.tracemem_b    = j37;
      end
      IR_BREAK: begin
        t.break_a    = ~j36 & j37;
        t.no_break_a = ~j36 & ~j37;
        t.break_b    = j36 & ~j35 & j37;
        t.no_break_b = j36 & ~j35 & ~j37;
        t.break_c    = j36 & j35 & j37;
        t.no_break_c = j36 & j35 & ~j37;
      end
      IR_TRACECTRL: begin
        t.tracectrl = j15;
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nios_jtag_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, with a rising-edge pulse
// taken from the last stage.
module nios_jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios_jtag_debug_sysclk_decoder.sv
// System-clock half of the OCI JTAG debug path: resynchronises update strobes,
// captures IR and the shift register, and issues one-cycle command pulses.
module nios_jtag_debug_sysclk_decoder
  import nios_jtag_dbg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SR_W        = SR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic            vs_uir,
  input  logic            vs_udr,
  output logic [SR_W-1:0] jdo,
  output logic            take_action_ocimem_a,
  output logic            take_action_ocimem_b,
  output logic            take_no_action_ocimem_a,
  output logic            take_action_tracemem_a,
  output logic            take_action_tracemem_b,
  output logic            take_no_action_tracemem_a,
  output logic            take_action_break_a,
  output logic            take_action_break_b,
  output logic            take_action_break_c,
  output logic            take_no_action_break_a,
  output logic            take_no_action_break_b,
  output logic            take_no_action_break_c,
  output logic            take_action_tracectrl
);

  // One count beyond the synchroniser depth covers the edge produced by a
  // strobe that is already high when reset releases.
  localparam int ARM_LOAD = SYNC_STAGES + 1;
  localparam int ARM_W    = $clog2(ARM_LOAD + 1);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic             uir_rise, udr_rise;
  logic             uir_take, udr_take;
  ir_e              ir_q, ir_d;
  logic [SR_W-1:0]  jdo_q, jdo_d;
  logic             strobe_q, strobe_d;
  take_t            take_q, take_d;

  nios_jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_rise)
  );

  nios_jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_rise)
  );

  always_comb begin
    armed     = (arm_cnt_q == '0);
    uir_take  = uir_rise & armed;
    udr_take  = udr_rise & armed;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q - ARM_W'(1);
    ir_d      = uir_take ? ir_e'(ir_in) : ir_q;
    jdo_d     = udr_take ? sr : jdo_q;
    strobe_d  = udr_take;
    take_d    = '0;
    // Decode sees ir_q/jdo_q after the capture, so a same-cycle IR update wins.
    if (strobe_q) begin
      take_d = decode_cmd(ir_q, jdo_q[JDO_B37], jdo_q[JDO_B36], jdo_q[JDO_B35],
                          jdo_q[JDO_B34], jdo_q[JDO_B15]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_q <= ARM_W'(ARM_LOAD);
      ir_q      <= IR_OCIMEM;
      jdo_q     <= '0;
      strobe_q  <= 1'b0;
      take_q    <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      ir_q      <= ir_d;
      jdo_q     <= jdo_d;
      strobe_q  <= strobe_d;
      take_q    <= take_d;
    end
  end

  assign jdo                       = jdo_q;
  assign take_action_ocimem_a      = take_q.ocimem_a;
  assign take_action_ocimem_b      = take_q.ocimem_b;
  assign take_no_action_ocimem_a   = take_q.no_ocimem_a;
  assign take_action_tracemem_a    = take_q.tracemem_a;
  assign take_action_tracemem_b    = take_q.tracemem_b;
  assign take_no_action_tracemem_a = take_q.no_tracemem_a;
  assign take_action_break_a       = take_q.break_a;
  assign take_action_break_b       = take_q.break_b;
  assign take_action_break_c       = take_q.break_c;
  assign take_no_action_break_a    = take_q.no_break_a;
  assign take_no_action_break_b    = take_q.no_break_b;
  assign take_no_action_break_c    = take_q.no_break_c;
  assign take_action_tracectrl     = take_q.tracectrl;

endmodule

// File: tb/tb_nios_jtag_debug_sysclk_decoder.sv
// Randomised self-checking bench: each command's expected pulse comes from a
// table-style model of the JTAG command set.
module tb_nios_jtag_debug_sysclk_decoder;

  localparam int N = 2;
  localparam int W = 38;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ir_in;
  logic [W-1:0] sr;
  logic         vs_uir, vs_udr;
  logic [W-1:0] jdo;
  logic ta_oa, ta_ob, tn_oa, ta_ta, ta_tb, tn_ta;
  logic ta_ba, ta_bb, ta_bc, tn_ba, tn_bb, tn_bc, ta_tc;
  logic [12:0]  takes;
  logic [1:0]   model_ir;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  nios_jtag_debug_sysclk_decoder #(.SYNC_STAGES(N), .SR_W(W)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ir_in                     (ir_in),
    .sr                        (sr),
    .vs_uir                    (vs_uir),
    .vs_udr                    (vs_udr),
    .jdo                       (jdo),
    .take_action_ocimem_a      (ta_oa),
    .take_action_ocimem_b      (ta_ob),
    .take_no_action_ocimem_a   (tn_oa),
    .take_action_tracemem_a    (ta_ta),
    .take_action_tracemem_b    (ta_tb),
    .take_no_action_tracemem_a (tn_ta),
    .take_action_break_a       (ta_ba),
    .take_action_break_b       (ta_bb),
    .take_action_break_c       (ta_bc),
    .take_no_action_break_a    (tn_ba),
    .take_no_action_break_b    (tn_bb),
    .take_no_action_break_c    (tn_bc),
    .take_action_tracectrl     (ta_tc)
  );

  assign takes = {ta_oa, ta_ob, tn_oa, ta_ta, ta_tb, tn_ta,
                  ta_ba, ta_bb, ta_bc, tn_ba, tn_bb, tn_bc, ta_tc};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit order: ocimem a,b,no_a | tracemem a,b,no_a | break a,b,c | no_break a,b,c | tracectrl
  function automatic logic [12:0] model(input logic [1:0] ir, input logic [W-1:0] s);
    logic [12:0] v;
    int          grp;
    v = '0;
    case (ir)
      2'd0: if (s[35]) v[11] = 1'b1; else if (s[34]) v[12] = 1'b1; else v[10] = 1'b1;
      2'd1: if (s[37]) v[8] = 1'b1; else if (s[36]) v[9] = 1'b1; else v[7] = 1'b1;
      2'd2: begin
        grp = !s[36] ? 0 : (s[35] ? 2 : 1);
        if (s[37]) v[6-grp] = 1'b1; else v[3-grp] = 1'b1;
      end
      default: v[0] = s[15];
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] rand_sr();
    return {6'($urandom), 32'($urandom)};
  endfunction

  task automatic load_ir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (N + 3) tick();
    vs_uir = 1'b0;
    repeat (N + 2) tick();
    model_ir = ir;
    chk("idle_after_uir", 64'(takes), 64'd0);
  endtask

  // The rise is driven just after an edge; the pulse shows up after N+2 edges
  // (N+3 clk counting the partial cycle the rise lands in).
  task automatic run_dr(input string tag, input logic [W-1:0] s,
                        input logic with_uir, input logic [1:0] ir);
    logic [12:0] exp;
    sr = s;
    if (with_uir) begin
      ir_in    = ir;
      vs_uir   = 1'b1;
      model_ir = ir;
    end
    vs_udr = 1'b1;
    exp = model(model_ir, s);
    for (int i = 1; i <= N + 5; i++) begin
      tick();
      chk({tag, "_take"}, 64'(takes), (i == N + 2) ? 64'(exp) : 64'd0);
    end
    chk({tag, "_jdo"}, 64'(jdo), 64'(s));
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (N + 2) tick();
  endtask

  initial begin
    logic [W-1:0] s;
    logic [1:0]   ir;
    logic         together;

    reset    = 1'b1;
    ir_in    = 2'b11;
    sr       = '1;
    vs_uir   = 1'b1;
    vs_udr   = 1'b1;
    model_ir = 2'b00;
    repeat (3) tick();
    chk("reset_takes", 64'(takes), 64'd0);
    chk("reset_jdo", 64'(jdo), 64'd0);

    // strobes already high at release must be swallowed by the arm window
    reset = 1'b0;
    for (int i = 1; i <= N + 6; i++) begin
      tick();
      chk("arm_take", 64'(takes), 64'd0);
    end
    chk("arm_jdo", 64'(jdo), 64'd0);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (N + 3) tick();

    load_ir(2'b00);
    s = rand_sr(); s[35:34] = 2'b01;
    run_dr("ocimem_a", s, 1'b0, 2'b00);

    load_ir(2'b10);
    s = rand_sr(); s[37:35] = 3'b111;
    run_dr("break_c", s, 1'b0, 2'b10);
    s = rand_sr(); s[37:35] = 3'b011;
    run_dr("no_break_c", s, 1'b0, 2'b10);

    load_ir(2'b11);
    s = rand_sr(); s[15] = 1'b1;
    run_dr("tracectrl", s, 1'b0, 2'b11);
    s = rand_sr(); s[15] = 1'b0;
    run_dr("tracectrl_off", s, 1'b0, 2'b11);

    load_ir(2'b10);
    s = rand_sr(); s[37:36] = 2'b01;
    run_dr("together_tracemem_a", s, 1'b1, 2'b01);

    // reset landing in the strobe cycle of a break_a command
    load_ir(2'b10);
    s = rand_sr(); s[37:36] = 2'b10;
    sr = s;
    vs_udr = 1'b1;
    repeat (N + 1) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_takes_now", 64'(takes), 64'd0);
    vs_udr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_takes", 64'(takes), 64'd0);
    end
    chk("rst_mid_jdo", 64'(jdo), 64'd0);
    reset    = 1'b0;
    model_ir = 2'b00;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      chk("rst_mid_after", 64'(takes), 64'd0);
    end
    load_ir(2'b10);
    s = rand_sr(); s[37:36] = 2'b10;
    run_dr("post_rst_break_a", s, 1'b0, 2'b10);

    for (int k = 0; k < 40; k++) begin
      ir       = 2'($urandom_range(0, 3));
      together = 1'($urandom_range(0, 1));
      s        = rand_sr();
      if (!together) load_ir(ir);
      run_dr("rand", s, together, ir);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
